mem_arbiter: RTL

Arbiter and sequencer that shares one single-ported memory between the processor's instruction-fetch path and its load/store data path. Each requester uses a req/ack handshake. The arbiter grants one requester at a time and drives the memory port for exactly one issue cycle. It waits a fixed read latency and returns read data with a one-cycle ack pulse. Data accesses normally win arbitration; a starvation guard forces a fetch grant after a bounded streak of data grants.

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter sequencing one single-ported memory
module mem_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);
  localparam logic [2:0] S_MAX  = 3'(STARVE_MAX);

  state_t      state, state_nxt;
  logic        gnt_if;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  wait_cnt;
  logic [2:0]  starve_cnt;
  logic        any_req;
  logic        pick_if;

  assign any_req = if_req | d_req;
  // Data wins unless the fetch side has already lost STARVE_MAX times in a row.
  assign pick_if = if_req & (~d_req | (starve_cnt == S_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? RESP : WAIT;
      WAIT:    if (wait_cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_if     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      wait_cnt   <= 3'd0;
      starve_cnt <= 3'd0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          gnt_if    <= pick_if;
          lat_we    <= ~pick_if & d_we;
          lat_addr  <= pick_if ? if_addr : d_addr;
          lat_wdata <= pick_if ? 32'h0 : d_wdata;
          if (pick_if || !if_req)   starve_cnt <= 3'd0;
          else if (starve_cnt != S_MAX) starve_cnt <= starve_cnt + 3'd1;
        end
        ISSUE: wait_cnt <= LAT_M1;
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (gnt_if) if_rdata <= m_rdata;
            else        d_rdata  <= m_rdata;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port outputs are zeroed outside the issue cycle.
  assign m_en    = (state == ISSUE);
  assign m_we    = m_en & lat_we;
  assign m_addr  = m_en ? lat_addr : 32'h0;
  assign m_wdata = m_we ? lat_wdata : 32'h0;
  assign if_ack  = (state == RESP) & gnt_if;
  assign d_ack   = (state == RESP) & ~gnt_if;
  assign busy    = (state != IDLE);

endmodule
